// File: rtl/text_injector_pkg.sv
// Shared types and constants for the paced ASCII text injector.
// Imported by the injector top and its bench.
package text_injector_pkg;

    typedef enum logic [1:0] {
        NL_PASS   = 2'd0,
        NL_LF2CR  = 2'd1,
        NL_DROPLF = 2'd2
    } nl_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } inj_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_NUL = 8'h00;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= 8'h61 && c <= 8'h7A) begin
            return c - 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/text_injector_if.sv
// Download stream (HPS ioctl) and character output handshake of the text injector.
// The injector uses the slave view; the host/keyboard side uses master.
interface text_injector_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_dout, char_ready,
        input  ioctl_wait, char_valid, char_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_dout, char_ready,
        output ioctl_wait, char_valid, char_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO on an inferred dual-port RAM with registered read data.
// Full pushes and empty pops are ignored; flush empties it without touching RAM.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill_q;
    logic [WIDTH-1:0] dout_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush & (fill_q != FULL);
    assign do_pop  = pop & ~flush & (fill_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            dout_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            fill_q <= fill_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign dout = dout_q;
    assign fill = fill_q;

endmodule

// File: rtl/text_injector.sv
// Paced ASCII text injector: filters the HPS download stream into a FIFO and
// feeds it to the keyboard/ACIA input with per-character and per-line gaps.
module text_injector
    import text_injector_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned CHAR_GAP = 500000,
    parameter int unsigned LINE_GAP = 5000000
) (
    input  logic                   clk,
    input  logic                   n_reset,
    text_injector_if.slave         io,
    input  logic                   enable,
    input  logic [1:0]             nl_mode,
    input  logic                   case_up,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(LINE_GAP + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic          dl_q;
    logic          dl_rise;
    logic [7:0]    byte_f;
    logic          keep;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fill_full;
    logic [FW-1:0] fill_next;
    logic          overflow_q;
    logic          wait_q;
    logic [7:0]    fifo_dout;
    inj_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign dl_rise = io.ioctl_download & ~dl_q;

    // Filter: NUL always dropped, LF handling by nl_mode (3 behaves as pass).
    always_comb begin
        byte_f = io.ioctl_dout;
        keep   = 1'b1;
        if (case_up) begin
            byte_f = to_upper(io.ioctl_dout);
        end
        if (io.ioctl_dout == ASCII_NUL) begin
            keep = 1'b0;
        end else if (io.ioctl_dout == ASCII_LF) begin
            case (nl_mode)
                NL_LF2CR:  byte_f = ASCII_CR;
                NL_DROPLF: keep = 1'b0;
                default:   ;
            endcase
        end
    end

    assign push_req  = io.ioctl_wr & keep;
    assign fill_full = (fill == FULL);
    assign push_ok   = push_req & ~fill_full & ~dl_rise;
    assign fill_next = dl_rise ? '0 : fill + FW'(push_ok) - FW'(pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .flush   (dl_rise),
        .push    (push_req),
        .din     (byte_f),
        .pop     (pop),
        .dout    (fifo_dout),
        .fill    (fill)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
            wait_q     <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
        end else begin
            dl_q       <= io.ioctl_download;
            // A new download clears the sticky flag even if this cycle would set it.
            overflow_q <= dl_rise ? 1'b0 : (overflow_q | (push_req & fill_full));
            wait_q     <= (fill_next >= FULL - FW'(1));
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (dl_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && fill != '0) begin
                        pop     = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (io.char_ready) begin
                        state_d = GAP;
                        cnt_d   = (io.char_data == ASCII_CR) ? CW'(LINE_GAP) : CW'(CHAR_GAP);
                    end
                end
                GAP: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The FIFO read register only changes on a pop, which happens only in IDLE,
    // so it doubles as the char_data holding register.
    assign io.char_data  = fifo_dout;
    assign io.char_valid = (state_q == SEND);
    assign io.ioctl_wait = wait_q;
    assign busy          = (fill != '0) || (state_q != IDLE);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_text_injector.sv
// Directed bench for text_injector: send timing, filtering, back-pressure,
// stalled consumer, download restart and reset during SEND.
module tb_text_injector;
    import text_injector_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned CHAR_GAP = 3;
    localparam int unsigned LINE_GAP = 10;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       enable;
    logic [1:0] nl_mode;
    logic       case_up;
    logic       busy;
    logic       overflow;
    logic [3:0] fill;

    int n_assert = 0;
    int n_fail   = 0;

    text_injector_if bus ();

    text_injector #(
        .DEPTH    (DEPTH),
        .CHAR_GAP (CHAR_GAP),
        .LINE_GAP (LINE_GAP)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .io       (bus.slave),
        .enable   (enable),
        .nl_mode  (nl_mode),
        .case_up  (case_up),
        .busy     (busy),
        .overflow (overflow),
        .fill     (fill)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_dout = b;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!bus.char_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Expects char_ready=1; checks the next character and completes its handshake.
    task automatic get_char(input string tag, input logic [7:0] exp);
        int n;
        wait_valid(0, n);
        check(tag, {bus.char_valid, bus.char_data}, {1'b1, exp});
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int   n;
        logic stable;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_dout     = 8'h00;
        bus.char_ready     = 1'b1;
        n_reset = 1'b0;
        enable  = 1'b1;
        nl_mode = 2'd0;
        case_up = 1'b0;
        repeat (3) tick();

        check("rst_valid", bus.char_valid, 0);
        check("rst_data", bus.char_data, 8'h00);
        check("rst_wait", bus.ioctl_wait, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fill", fill, 0);

        // Basic send of "AB\r", bytes streamed back to back.
        n_reset = 1'b1;
        bus.ioctl_download = 1'b1;
        repeat (2) tick();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_dout = 8'h41;
        tick();
        check("lat_t1_fill", fill, 1);
        check("lat_t1_valid", bus.char_valid, 0);
        bus.ioctl_dout = 8'h42;
        tick();
        check("lat_t2_char", {bus.char_valid, bus.char_data}, {1'b1, 8'h41});
        check("lat_t2_fill", fill, 1);
        bus.ioctl_dout = ASCII_CR;
        tick();
        bus.ioctl_wr = 1'b0;
        check("gap_start_valid", bus.char_valid, 0);
        check("gap_start_fill", fill, 2);
        wait_valid(1, n);
        check("char_gap_a", n, CHAR_GAP + 2);
        check("char_b", bus.char_data, 8'h42);
        tick();
        wait_valid(1, n);
        check("char_gap_b", n, CHAR_GAP + 2);
        check("char_cr", bus.char_data, 8'h0D);
        repeat (LINE_GAP) tick();
        check("line_gap_busy", busy, 1);
        check("line_gap_valid", bus.char_valid, 0);
        tick();
        check("line_gap_end_busy", busy, 0);
        check("line_gap_end_fill", fill, 0);

        // Filtering: LF->CR with upper-casing.
        enable  = 1'b0;
        nl_mode = 2'd1;
        case_up = 1'b1;
        wr(8'h61); wr(8'h00); wr(8'h0A); wr(8'h7B);
        check("filt1_fill", fill, 3);
        check("filt1_overflow", overflow, 0);
        enable = 1'b1;
        get_char("filt1_c0", 8'h41);
        get_char("filt1_c1", 8'h0D);
        get_char("filt1_c2", 8'h7B);
        wait_idle("filt1_idle");

        // Filtering: LF dropped.
        enable  = 1'b0;
        nl_mode = 2'd2;
        wr(8'h61); wr(8'h00); wr(8'h0A); wr(8'h7B);
        check("filt2_fill", fill, 2);
        check("filt2_overflow", overflow, 0);
        enable = 1'b1;
        get_char("filt2_c0", 8'h41);
        get_char("filt2_c1", 8'h7B);
        wait_idle("filt2_idle");

        // Back-pressure and overflow with output disabled.
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(8'(8'h30 + i));
            if (i == 5) begin
                check("bp_fill6", fill, 6);
                check("bp_wait6", bus.ioctl_wait, 0);
            end
            if (i == 6) begin
                check("bp_fill7", fill, 7);
                check("bp_wait7", bus.ioctl_wait, 1);
            end
            if (i == 7) begin
                check("bp_fill8", fill, 8);
                check("bp_ovf8", overflow, 0);
            end
            if (i == 8) begin
                check("bp_fill9", fill, 8);
                check("bp_ovf9", overflow, 1);
                check("bp_wait9", bus.ioctl_wait, 1);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            get_char("bp_order", 8'(8'h30 + i));
        end
        wait_idle("bp_idle");
        check("bp_ovf_sticky", overflow, 1);
        check("bp_wait_clear", bus.ioctl_wait, 0);

        // Stalled consumer.
        bus.char_ready = 1'b0;
        wr(8'h55);
        wait_valid(0, n);
        check("stall_first", {bus.char_valid, bus.char_data}, {1'b1, 8'h55});
        wr(8'h56);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(bus.char_valid === 1'b1 && bus.char_data === 8'h55)) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        check("stall_fill", fill, 1);
        bus.char_ready = 1'b1;
        tick();
        check("stall_hs_valid", bus.char_valid, 0);
        wait_valid(1, n);
        check("stall_gap", n, CHAR_GAP + 2);
        check("stall_next", bus.char_data, 8'h56);
        tick();
        wait_idle("stall_idle");

        // Restart: falling edge keeps data, rising edge in GAP flushes everything.
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr(8'(8'h10 + i));
        end
        bus.ioctl_download = 1'b0;
        repeat (2) tick();
        check("fall_noflush", fill, 6);
        enable = 1'b1;
        wait_valid(0, n);
        check("rs_first", {bus.char_valid, bus.char_data}, {1'b1, 8'h10});
        tick();
        check("rs_gap_fill", fill, 5);
        check("rs_gap_valid", bus.char_valid, 0);
        bus.ioctl_download = 1'b1;
        tick();
        check("rs_fill", fill, 0);
        check("rs_overflow", overflow, 0);
        check("rs_busy", busy, 0);
        check("rs_valid", bus.char_valid, 0);
        wr(8'h22);
        get_char("rs_new", 8'h22);
        wait_idle("rs_idle");
        check("rs_end_fill", fill, 0);

        // Reset during SEND.
        bus.char_ready = 1'b0;
        wr(8'h33);
        wait_valid(0, n);
        check("rst_send_pre", {bus.char_valid, bus.char_data}, {1'b1, 8'h33});
        n_reset = 1'b0;
        tick();
        check("rst_send_valid", bus.char_valid, 0);
        check("rst_send_data", bus.char_data, 8'h00);
        check("rst_send_busy", busy, 0);
        check("rst_send_fill", fill, 0);
        n_reset = 1'b1;
        bus.char_ready = 1'b1;
        repeat (3) tick();
        check("rst_send_after", bus.char_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
